// File: rtl/approx_add_pkg.sv
// Shared types and elaboration helpers for the pipelined approximate adder.
package approx_add_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_LOA   = 2'd1,
        MODE_TRUNC = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int unsigned MinStages = 1;
    localparam int unsigned MaxStages = 4;

    // Upper part split into near-equal segments; leftover bits go to the lowest ones.
    function automatic int unsigned seg_width(input int unsigned width, input int unsigned k,
                                              input int unsigned stages, input int unsigned s);
        int unsigned u;
        u = width - k;
        return (u / stages) + ((s < (u % stages)) ? 1 : 0);
    endfunction

    function automatic int unsigned seg_offset(input int unsigned width, input int unsigned k,
                                               input int unsigned stages, input int unsigned s);
        int unsigned off;
        off = k;
        for (int unsigned i = 0; i < s; i++) begin
            off += seg_width(width, k, stages, i);
        end
        return off;
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned k,
                                        input int unsigned stages);
        return (width >= 1) && (k < width) && (stages >= MinStages) && (stages <= MaxStages);
    endfunction

endpackage

// File: rtl/approx_add_seg.sv
// One registered slice of the exact upper carry chain.
module approx_add_seg #(
    parameter int unsigned W  = 1,
    localparam int unsigned SW = (W > 0) ? W : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o
);

    logic [SW:0]   full;
    logic [SW-1:0] sum_q;
    logic          cout_q;

    assign full = {1'b0, a_i} + {1'b0, b_i} + {{SW{1'b0}}, cin_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= full[SW-1:0];
            // An empty segment just forwards the carry to the next stage.
            cout_q <= (W == 0) ? cin_i : full[SW];
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate unsigned adder (EXACT / LOA / TRUNC low part, segmented exact upper part).
// Optional error statistics are built when APPROX_ERR_STATS_EN is defined.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 4,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
`ifdef APPROX_ERR_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] err_sum,
    output logic [WIDTH:0]   err_max,
    output logic [CNT_W-1:0] sample_cnt
`endif
);

    localparam int unsigned SumW = WIDTH + 1;
    localparam bit ParamsOk = params_legal(WIDTH, APPROX_BITS, STAGES);

    if (!ParamsOk) begin : g_bad_params
        $error("approx_add_pipe: illegal WIDTH/APPROX_BITS/STAGES combination");
    end

    logic              advance;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES:0]   carry;
    logic [WIDTH:0]    res_lo;
    logic              cin_lo;
    logic [WIDTH-1:0]  a_in    [STAGES];
    logic [WIDTH-1:0]  b_in    [STAGES];
    logic [WIDTH:0]    res_in  [STAGES];
    logic [WIDTH:0]    res_out [STAGES];

    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign valid_d   = (valid_q << 1) | STAGES'(in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= valid_d;
        end
    end

    if (APPROX_BITS > 0) begin : g_low
        localparam int unsigned K = APPROX_BITS;
        mode_e        mode;
        logic [K:0]   lo_exact;
        logic [K-1:0] lo;

        assign mode     = mode_e'(in_mode);
        assign lo_exact = {1'b0, in_a[K-1:0]} + {1'b0, in_b[K-1:0]};

        always_comb begin
            lo     = lo_exact[K-1:0];
            cin_lo = lo_exact[K];
            unique case (mode)
                MODE_LOA: begin
                    lo     = in_a[K-1:0] | in_b[K-1:0];
                    cin_lo = in_a[K-1] & in_b[K-1];
                end
                MODE_TRUNC: begin
                    lo       = '0;
                    lo[K-1]  = 1'b1;
                    cin_lo   = 1'b0;
                end
                default: ;
            endcase
        end

        assign res_lo = SumW'(lo);
    end else begin : g_no_low
        assign res_lo = '0;
        assign cin_lo = 1'b0;
    end

    assign carry[0]  = cin_lo;
    assign a_in[0]   = in_a;
    assign b_in[0]   = in_b;
    assign res_in[0] = res_lo;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned SegW  = seg_width(WIDTH, APPROX_BITS, STAGES, s);
        localparam int unsigned SegOf = seg_offset(WIDTH, APPROX_BITS, STAGES, s);
        localparam int unsigned SegPw = (SegW > 0) ? SegW : 1;

        logic [SegPw-1:0] seg_a, seg_b, seg_sum;
        logic [WIDTH:0]   res_q;

        if (SegW > 0) begin : g_ops
            assign seg_a      = a_in[s][SegOf +: SegPw];
            assign seg_b      = b_in[s][SegOf +: SegPw];
            assign res_out[s] = res_q | (SumW'(seg_sum) << SegOf);
        end else begin : g_no_ops
            assign seg_a      = '0;
            assign seg_b      = '0;
            assign res_out[s] = res_q;
        end

        approx_add_seg #(
            .W(SegW)
        ) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (advance),
            .a_i   (seg_a),
            .b_i   (seg_b),
            .cin_i (carry[s]),
            .sum_o (seg_sum),
            .cout_o(carry[s+1])
        );

        // Bits already resolved ride along so the whole sum leaves the last stage together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_q <= '0;
            end else if (advance) begin
                res_q <= res_in[s];
            end
        end

        if (s + 1 < STAGES) begin : g_fwd
            logic [WIDTH-1:0] a_q, b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_in[s];
                    b_q <= b_in[s];
                end
            end

            assign a_in[s+1]   = a_q;
            assign b_in[s+1]   = b_q;
            assign res_in[s+1] = res_out[s];
        end
    end

    assign out_sum = res_out[STAGES-1] | {carry[STAGES], {WIDTH{1'b0}}};

`ifdef APPROX_ERR_STATS_EN
    localparam int unsigned AccW = CNT_W + 1;

    logic [WIDTH:0]   exact_q [STAGES];
    logic [WIDTH:0]   err;
    logic [AccW-1:0]  err_acc;
    logic [CNT_W-1:0] err_sum_q, sample_cnt_q;
    logic [WIDTH:0]   err_max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(STAGES); s++) exact_q[s] <= '0;
        end else if (advance) begin
            exact_q[0] <= {1'b0, in_a} + {1'b0, in_b};
            for (int s = 1; s < int'(STAGES); s++) exact_q[s] <= exact_q[s-1];
        end
    end

    assign err     = (exact_q[STAGES-1] >= out_sum) ? exact_q[STAGES-1] - out_sum
                                                    : out_sum - exact_q[STAGES-1];
    assign err_acc = {1'b0, err_sum_q} + AccW'(err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum_q    <= '0;
            err_max_q    <= '0;
            sample_cnt_q <= '0;
        end else if (stats_clr) begin
            err_sum_q    <= '0;
            err_max_q    <= '0;
            sample_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            err_sum_q <= err_acc[CNT_W] ? '1 : err_acc[CNT_W-1:0];
            if (err > err_max_q) err_max_q <= err;
            if (sample_cnt_q != '1) sample_cnt_q <= sample_cnt_q + 1'b1;
        end
    end

    assign err_sum    = err_sum_q;
    assign err_max    = err_max_q;
    assign sample_cnt = sample_cnt_q;
`endif

endmodule
